// File: rtl/cfg_lut_fgen.sv
// rtl/cfg_lut_fgen.sv - programmable N-input truth-table function generator with serial table load
module cfg_lut_fgen #(
    parameter int                N       = 5,
    parameter logic [(1<<N)-1:0] INIT    = '0,
    parameter int                INIT_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                y,
    output logic                y_valid,
    output logic [(1<<N)-1:0]   table_q
);

    localparam int T = 1 << N;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (INIT_EN != 0) ? ACTIVE : EMPTY;

    state_t      state;
    state_t      state_next;
    logic [N:0]  count;
    logic        accept;
    logic        last_bit;

    // A start pulse always wins over a bit offered in the same cycle.
    assign cfg_ready = (state == LOAD);
    assign accept    = cfg_valid && cfg_ready && !cfg_start;
    assign last_bit  = accept && (count == (N+1)'(T - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start (re)enters LOAD from any state, the final bit completes it.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (cfg_start) state_next = LOAD;
            LOAD:    if (cfg_start) state_next = LOAD;
                     else if (last_bit) state_next = ACTIVE;
            ACTIVE:  if (cfg_start) state_next = LOAD;
            default: state_next = RESET_STATE;
        endcase
    end

    // Serial table shift (index T-1 arrives first), bit counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q  <= INIT;
            count    <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= last_bit;
            if (accept) begin
                table_q <= {table_q[T-2:0], cfg_bit};
            end
            if (cfg_start || last_bit) begin
                count <= '0;
            end else if (accept) begin
                count <= count + 1'b1;
            end
        end
    end

    // Registered lookup; output is forced low whenever the table is not usable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else if (state == ACTIVE) begin
            y       <= table_q[in];
            y_valid <= 1'b1;
        end else begin
            y       <= 1'b0;
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cfg_lut_fgen.sv
// tb/tb_cfg_lut_fgen.sv - scoreboard bench for cfg_lut_fgen with a bit-queue reference model
module tb_cfg_lut_fgen;

    localparam int          N      = 5;
    localparam logic [31:0] INIT_V = 32'h8000_0000;
    localparam int          M_EMPTY = 0, M_LOAD = 1, M_ACTIVE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_v;
    logic        cfg_start, cfg_valid, cfg_bit;
    logic        a_cfg_ready, a_cfg_done, a_y, a_y_valid;
    logic [31:0] a_table_q;
    logic        b_cfg_ready, b_cfg_done, b_y, b_y_valid;
    logic [31:0] b_table_q;

    cfg_lut_fgen #(.N(N), .INIT(INIT_V), .INIT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .in(in_v),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(a_cfg_ready), .cfg_done(a_cfg_done),
        .y(a_y), .y_valid(a_y_valid), .table_q(a_table_q)
    );

    cfg_lut_fgen #(.N(N), .INIT(INIT_V), .INIT_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in(in_v),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(b_cfg_ready), .cfg_done(b_cfg_done),
        .y(b_y), .y_valid(b_y_valid), .table_q(b_table_q)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    int          hs_dut = 0;
    logic        exp_q[$];
    logic        mbits[$];
    logic [31:0] mtable;
    int          mstate;
    logic        mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every valid output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_y_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL y_valid_unexpected actual=1 required=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (a_y !== mon_e) begin
                        errors++;
                        $display("FAIL y_value actual=%b required=%b", a_y, mon_e);
                    end
                end
            end else begin
                checks++;
                if (a_y !== 1'b0) begin
                    errors++;
                    $display("FAIL y_idle_low actual=%b required=0", a_y);
                end
            end
            if (a_cfg_done) done_seen++;
        end
    end

    // One clock of stimulus; expectation pushed and model advanced per the block's rules.
    task automatic step(input logic [4:0] i, input logic s, input logic v, input logic b);
        in_v = i; cfg_start = s; cfg_valid = v; cfg_bit = b;
        chk("cfg_ready", a_cfg_ready, (mstate == M_LOAD));
        if (v && a_cfg_ready && !s) hs_dut++;
        if (mstate == M_ACTIVE) exp_q.push_back(mtable[i]);
        if (s) begin
            mstate = M_LOAD;
            mbits.delete();
        end else if (mstate == M_LOAD && v) begin
            mbits.push_back(b);
            if (mbits.size() == 32) begin
                for (int k = 0; k < 32; k++) mtable[31-k] = mbits[k];
                mstate = M_ACTIVE;
                done_exp++;
            end
        end
        @(posedge clk);
        #1;
        chk("scoreboard_backlog", (exp_q.size() <= 1), 1);
    endtask

    task automatic load_bits(input logic [31:0] w, input int gap_pct);
        for (int k = 31; k >= 0; k--) begin
            while ($urandom_range(0, 99) < gap_pct)
                step(5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'($urandom));
            step(5'($urandom_range(0, 31)), 1'b0, 1'b1, w[k]);
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) step(i[4:0], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        in_v = '0; cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
        mstate = M_ACTIVE; mtable = INIT_V;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs_a", {a_y, a_y_valid, a_cfg_ready, a_cfg_done}, 0);
        chk("rst_outputs_b", {b_y, b_y_valid, b_cfg_ready, b_cfg_done}, 0);
        chk("rst_table_a", a_table_q, INIT_V);
        chk("rst_table_b", b_table_q, INIT_V);
        rst = 0;

        // INIT table active straight out of reset
        step(5'd31, 1'b0, 1'b0, 1'b0);
        chk("y_valid_after_reset", a_y_valid, 1);
        sweep();

        // INIT_EN=0 instance stays empty
        for (int c = 0; c < 10; c++) begin
            step(5'($urandom_range(0, 31)), 1'b0, 1'b1, 1'($urandom));
            chk("empty_b_outputs", {b_y, b_y_valid, b_cfg_ready}, 0);
        end
        step(5'd3, 1'b1, 1'b0, 1'b0);
        chk("start_b_ready", b_cfg_ready, 1);

        // parity table back-to-back
        load_bits(32'h6996_9669, 0);
        step(5'd0, 1'b0, 1'b0, 1'b0);
        chk("parity_table", a_table_q, 32'h6996_9669);
        chk("parity_done_count", done_seen, done_exp);
        chk("parity_done_total", done_seen, 1);
        sweep();

        // low-half table with ~50% valid gaps
        step(5'd7, 1'b1, 1'b1, 1'b1);
        hs_dut = 0;
        load_bits(32'h0000_FFFF, 50);
        step(5'd0, 1'b0, 1'b0, 1'b0);
        chk("gap_table", a_table_q, 32'h0000_FFFF);
        chk("gap_handshakes", hs_dut, 32);
        chk("gap_done_count", done_seen, done_exp);
        sweep();

        // restart mid-load, held start, start+valid collision
        step(5'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            step(5'($urandom_range(0, 31)), 1'b0, 1'b1, 1'($urandom));
            if (k == 5) chk("load_y_valid_low", a_y_valid, 0);
        end
        step(5'd2, 1'b1, 1'b1, 1'b1);
        step(5'd2, 1'b1, 1'b1, 1'b0);
        load_bits(32'hFFFF_0000, 30);
        step(5'd0, 1'b0, 1'b0, 1'b0);
        chk("restart_table", a_table_q, 32'hFFFF_0000);
        chk("restart_done_count", done_seen, done_exp);
        sweep();

        // asynchronous reset in the middle of a load
        step(5'd4, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(5'($urandom_range(0, 31)), 1'b0, 1'b1, 1'($urandom));
        #2 rst = 1;
        #1;
        chk("async_rst_table_a", a_table_q, INIT_V);
        chk("async_rst_table_b", b_table_q, INIT_V);
        chk("async_rst_outputs", {a_y_valid, a_cfg_ready, b_y_valid, b_cfg_ready}, 0);
        mstate = M_ACTIVE; mtable = INIT_V; mbits.delete(); exp_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        step(5'd31, 1'b0, 1'b0, 1'b0);
        chk("post_rst_a_valid", a_y_valid, 1);
        chk("post_rst_b_empty", {b_y_valid, b_cfg_ready}, 0);
        chk("post_rst_no_done", done_seen, done_exp);
        for (int c = 0; c < 8; c++) step(5'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
